// File: rtl/pulse_cmd_pkg.sv
// Shared constants for the pulse generator command controller: opcodes,
// framing bytes, FSM encoding and the edge-word width derivation.
package pulse_cmd_pkg;

  localparam logic [7:0] OP_STATE0    = 8'h00;
  localparam logic [7:0] OP_PER       = 8'h01;
  localparam logic [7:0] OP_ED        = 8'h02;
  localparam logic [7:0] OP_OUTER_PER = 8'h03;
  localparam logic [7:0] OP_PRINT     = 8'h04;
  localparam logic [7:0] OP_CLEAR     = 8'h05;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] NAK = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CLEAR,
    S_ACK
  } state_t;

  // Edge word: two counts, a channel index and a level bit.
  function automatic int ed_bits(input int count_bits, input int ch_log2);
    return 2 * count_bits + ch_log2 + 1;
  endfunction

endpackage

// File: rtl/pulse_cmd_if.sv
// UART-side byte handshake between the uart instance and pulse_cmd_ctrl.
interface pulse_cmd_if;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;

  modport master (
    output received, rx_byte, recv_error, is_transmitting,
    input  transmit, tx_byte
  );

  modport slave (
    input  received, rx_byte, recv_error, is_transmitting,
    output transmit, tx_byte
  );
endinterface

// File: rtl/pulse_cmd_rxbuf.sv
// Frame assembler: stores received bytes, detects CR/LF, and latches the
// frame length and bad status for the controller on completion.
module pulse_cmd_rxbuf
  import pulse_cmd_pkg::*;
#(
  parameter int BYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  recv_error,
  output logic [BYTES-1:0][7:0] frame,
  output logic [7:0]            len,
  output logic                  fbad,
  output logic                  done
);

  localparam int IW = $clog2(BYTES);

  logic [7:0] idx;
  logic [7:0] prev;
  logic       ovf;
  logic       bad;
  logic       full;

  assign full = (idx == 8'(BYTES));
  // prev tracks dropped bytes too, so a terminator is still seen after overflow
  assign done = received && (rx_byte == LF) && (prev == CR);

  always_ff @(posedge clk) begin
    if (received && !full) frame[idx[IW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      prev <= '0;
      ovf  <= 1'b0;
      bad  <= 1'b0;
      len  <= '0;
      fbad <= 1'b0;
    end else begin
      if (received) prev <= rx_byte;
      if (done) begin
        idx  <= '0;
        len  <= idx + 8'd1;
        fbad <= bad | ovf | recv_error | full;
        ovf  <= 1'b0;
        bad  <= 1'b0;
      end else begin
        if (received) begin
          if (full) ovf <= 1'b1;
          else      idx <= idx + 8'd1;
        end
        if (recv_error) bad <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_cmd_ctrl.sv
// Command decoder and configuration register file for pulse_logic; returns
// an ACK/NAK byte over the UART transmit handshake.
module pulse_cmd_ctrl
  import pulse_cmd_pkg::*;
#(
  parameter int BYTES      = 16,
  parameter int COUNT_BITS = 32,
  parameter int CH_LOG2    = 3,
  parameter int ED_MAX     = 64,
  parameter int ED_BITS    = ed_bits(COUNT_BITS, CH_LOG2)
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  pulse_cmd_if.slave              uart,
  output logic [(1<<CH_LOG2)-1:0] state0,
  output logic [COUNT_BITS-1:0]   period,
  output logic [COUNT_BITS-1:0]   outer_period,
  output logic                    ed_we,
  output logic [7:0]              ed_addr,
  output logic [ED_BITS-1:0]      ed_data,
  output logic                    logic_reset,
  output logic                    busy
);

  localparam int CH_MAX = 1 << CH_LOG2;

  logic [BYTES-1:0][7:0] frame;
  logic [7:0]            len;
  logic                  fbad;
  logic                  done;

  pulse_cmd_rxbuf #(.BYTES(BYTES)) u_rxbuf (
    .clk        (sys_clk),
    .rst        (rst),
    .received   (uart.received),
    .rx_byte    (uart.rx_byte),
    .recv_error (uart.recv_error),
    .frame      (frame),
    .len        (len),
    .fbad       (fbad),
    .done       (done)
  );

  state_t state, state_d;
  logic                  xmit, xmit_d;
  logic [7:0]            ack_byte, ack_byte_d;
  logic [CH_MAX-1:0]     state0_d;
  logic [COUNT_BITS-1:0] period_d, outer_d;
  logic                  ed_we_d, logic_reset_d;
  logic [7:0]            ed_addr_d;
  logic [ED_BITS-1:0]    ed_data_d;

  logic [7:0]  op;
  logic [31:0] f32;
  logic [71:0] f72;
  logic        wr, clr;
  logic [7:0]  resp;
  logic        unused_tail;

  assign op          = frame[0];
  assign unused_tail = ^frame[BYTES-1:12];
  assign uart.transmit = xmit;
  assign uart.tx_byte  = ack_byte;

  always_comb begin
    f32 = '0;
    f72 = '0;
    for (int i = 0; i < 4; i++) f32[i*8 +: 8] = frame[1+i];
    for (int i = 0; i < 9; i++) f72[i*8 +: 8] = frame[2+i];
  end

  // wr: a configuration write is due; clr: start the edge-table sweep
  always_comb begin
    wr   = 1'b0;
    clr  = 1'b0;
    resp = NAK;
    if (!fbad) begin
      case (op)
        OP_STATE0: if (len >= 8'd3) begin wr = 1'b1; resp = op; end
        OP_PER, OP_OUTER_PER:
          if (len >= 8'd6) begin wr = 1'b1; resp = op; end
        OP_ED:
          if (len >= 8'd12 && {1'b0, frame[1]} < 9'(ED_MAX)) begin
            wr = 1'b1; resp = op;
          end
        OP_PRINT: resp = op;
        OP_CLEAR: begin clr = 1'b1; resp = op; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state;
    xmit_d        = 1'b0;
    ack_byte_d    = ack_byte;
    state0_d      = state0;
    period_d      = period;
    outer_d       = outer_period;
    ed_we_d       = 1'b0;
    ed_addr_d     = ed_addr;
    ed_data_d     = ed_data;
    logic_reset_d = 1'b0;
    case (state)
      S_IDLE: if (done) state_d = S_EXEC;
      S_EXEC: begin
        ack_byte_d = resp;
        state_d    = S_ACK;
        if (clr) begin
          ed_we_d   = 1'b1;
          ed_addr_d = '0;
          ed_data_d = '0;
          state_d   = S_CLEAR;
        end else if (wr) begin
          logic_reset_d = 1'b1;
          case (op)
            OP_STATE0: state0_d = frame[1][CH_MAX-1:0];
            OP_PER:    period_d = COUNT_BITS'(f32);
            OP_OUTER_PER: outer_d = COUNT_BITS'(f32);
            default: begin
              ed_we_d   = 1'b1;
              ed_addr_d = frame[1];
              ed_data_d = ED_BITS'(f72);
            end
          endcase
        end else begin
          // nothing to write: the acknowledge can go out next cycle
          xmit_d = !uart.is_transmitting;
        end
      end
      S_CLEAR: begin
        if (ed_addr == 8'(ED_MAX-1)) begin
          logic_reset_d = 1'b1;
          state_d       = S_ACK;
        end else begin
          ed_we_d   = 1'b1;
          ed_addr_d = ed_addr + 8'd1;
          ed_data_d = '0;
        end
      end
      S_ACK: begin
        if (xmit) state_d = S_IDLE;
        else      xmit_d  = !uart.is_transmitting;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      xmit         <= 1'b0;
      ack_byte     <= '0;
      state0       <= '0;
      period       <= COUNT_BITS'(1);
      outer_period <= COUNT_BITS'(1);
      ed_we        <= 1'b0;
      ed_addr      <= '0;
      ed_data      <= '0;
      logic_reset  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      xmit         <= xmit_d;
      ack_byte     <= ack_byte_d;
      state0       <= state0_d;
      period       <= period_d;
      outer_period <= outer_d;
      ed_we        <= ed_we_d;
      ed_addr      <= ed_addr_d;
      ed_data      <= ed_data_d;
      logic_reset  <= logic_reset_d;
      busy         <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_cmd_ctrl.sv
// Directed bench for pulse_cmd_ctrl: command frames with hand-computed results.
module tb_pulse_cmd_ctrl;
  import pulse_cmd_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [7:0]  state0;
  logic [31:0] period, outer_period;
  logic        ed_we;
  logic [7:0]  ed_addr;
  logic [67:0] ed_data;
  logic        logic_reset, busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] fq[$];

  always #5 sys_clk = ~sys_clk;

  pulse_cmd_if u_if();

  pulse_cmd_ctrl dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .uart         (u_if),
    .state0       (state0),
    .period       (period),
    .outer_period (outer_period),
    .ed_we        (ed_we),
    .ed_addr      (ed_addr),
    .ed_data      (ed_data),
    .logic_reset  (logic_reset),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    u_if.received = 1'b1;
    u_if.rx_byte  = b;
    step();
    u_if.received = 1'b0;
  endtask

  task automatic send_fq();
    foreach (fq[i]) send(fq[i]);
  endtask

  // expects NAK at T+2 with no write and no restart
  task automatic nak_case(input string tag);
    step();
    chk({tag, "_tx"}, u_if.transmit, 1);
    chk({tag, "_byte"}, u_if.tx_byte, NAK);
    chk({tag, "_we"}, ed_we, 0);
    chk({tag, "_lr"}, logic_reset, 0);
    step();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   good, hits;
    logic hit;
    u_if.received = 0; u_if.rx_byte = 0; u_if.recv_error = 0;
    u_if.is_transmitting = 0;
    rst = 1;
    step(); step();
    chk("rst_tx", u_if.transmit, 0);
    chk("rst_byte", u_if.tx_byte, 0);
    chk("rst_state0", state0, 0);
    chk("rst_per", period, 1);
    chk("rst_outer", outer_period, 1);
    chk("rst_we", ed_we, 0);
    chk("rst_data", ed_data, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    step();

    fq = '{8'h01, 8'h10, 8'h27, 8'h00, 8'h00, CR, LF};
    send_fq();
    chk("per_busy", busy, 1);
    chk("per_pre", period, 1);
    step();
    chk("per_val", period, 10000);
    chk("per_lr", logic_reset, 1);
    chk("per_tx_early", u_if.transmit, 0);
    step();
    chk("per_tx", u_if.transmit, 1);
    chk("per_byte", u_if.tx_byte, 8'h01);
    chk("per_lr_off", logic_reset, 0);
    step();
    chk("per_idle", busy, 0);

    fq = '{8'h00, 8'hA5, CR, LF};
    send_fq(); step();
    chk("st0_val", state0, 8'hA5);
    chk("st0_lr", logic_reset, 1);
    step();
    chk("st0_tx", u_if.transmit, 1);
    chk("st0_byte", u_if.tx_byte, 8'h00);
    step();

    fq = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12, CR, LF};
    send_fq(); step();
    chk("outer_val", outer_period, 32'h12345678);
    step();
    chk("outer_byte", u_if.tx_byte, 8'h03);
    step();

    fq = '{8'h02, 8'h05, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, CR, LF};
    send_fq(); step();
    chk("ed_we", ed_we, 1);
    chk("ed_addr", ed_addr, 5);
    chk("ed_data", ed_data, 68'h91817161514131211);
    chk("ed_lr", logic_reset, 1);
    step();
    chk("ed_we_off", ed_we, 0);
    chk("ed_tx", u_if.transmit, 1);
    chk("ed_byte", u_if.tx_byte, 8'h02);
    step();

    fq = '{8'h05, CR, LF};
    send_fq();
    good = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (ed_we === 1'b1 && ed_addr === 8'(k) && ed_data === '0 && logic_reset === 1'b0) good++;
    end
    chk("clr_sweep", good, 64);
    step();
    chk("clr_we_off", ed_we, 0);
    chk("clr_lr", logic_reset, 1);
    step();
    chk("clr_tx", u_if.transmit, 1);
    chk("clr_byte", u_if.tx_byte, 8'h05);
    step();

    fq = '{8'h04, CR, LF};
    send_fq(); step();
    chk("prn_tx", u_if.transmit, 1);
    chk("prn_byte", u_if.tx_byte, 8'h04);
    chk("prn_lr", logic_reset, 0);
    step();

    fq = '{8'h02, 8'h40, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, CR, LF};
    send_fq(); nak_case("ed64");
    fq = '{8'h07, CR, LF};
    send_fq(); nak_case("op07");
    fq = {};
    for (int i = 0; i < 20; i++) fq.push_back(8'h01);
    fq.push_back(CR); fq.push_back(LF);
    send_fq(); nak_case("ovf");
    chk("ovf_per", period, 10000);
    fq = '{8'h01, 8'h10, CR, LF};
    send_fq(); nak_case("short");
    u_if.recv_error = 1;
    send(8'h01);
    u_if.recv_error = 0;
    fq = '{8'h10, 8'h27, 8'h00, 8'h00, CR, LF};
    send_fq(); nak_case("rxerr");

    u_if.is_transmitting = 1;
    fq = '{8'h01, 8'h20, 8'h00, 8'h00, 8'h00, CR, LF};
    send_fq();
    hits = 0;
    repeat (100) begin
      step();
      if (u_if.transmit) hits++;
    end
    chk("hold_no_tx", hits, 0);
    chk("hold_busy", busy, 1);
    chk("hold_per", period, 32);
    u_if.is_transmitting = 0;
    hit = 0;
    for (int i = 0; i < 5 && !hit; i++) begin
      if (u_if.transmit) hit = 1;
      else step();
    end
    chk("hold_tx", hit, 1);
    chk("hold_byte", u_if.tx_byte, 8'h01);
    step();

    fq = '{8'h05, CR, LF};
    send_fq();
    repeat (10) step();
    chk("mid_we", ed_we, 1);
    rst = 1;
    step();
    chk("abort_we", ed_we, 0);
    chk("abort_addr", ed_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_per", period, 1);
    chk("abort_tx", u_if.transmit, 0);
    rst = 0;
    hits = 0;
    repeat (80) begin
      step();
      if (u_if.transmit || ed_we) hits++;
    end
    chk("abort_quiet", hits, 0);

    fq = '{8'h04, CR, LF};
    send_fq(); step();
    chk("post_tx", u_if.transmit, 1);
    chk("post_byte", u_if.tx_byte, 8'h04);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
